// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer exposing a bank of 32-bit registers.
// Register 0 is a read-only ID word. The other registers are read/write and are cleared by reset.
// A sticky flag records protocol violations by the requester.
// Optional feature macro: APB_SLV_WAIT_EN. When it is defined, WAIT_CYCLES wait states are
// inserted in every ACCESS phase. When it is not defined, every transfer is zero-wait.
module apb_reg_slave #(
   parameter int          NUM_REGS    = 64,
   parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CA00,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0016,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic [31:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic        proto_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);
`ifdef APB_SLV_WAIT_EN
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
`else
   // WAIT_CYCLES has no effect in this build. The mask keeps the parameter referenced.
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES) & 4'h0;
`endif

   state_t      state;
   logic [31:0] paddr_q;
   logic        pwrite_q;
   logic [31:0] pwdata_q;
   logic [3:0]  wait_cnt;
   logic        proto_err_q;
   logic [31:0] regs [1:NUM_REGS-1];

   logic        setup_phase;
   logic        access_phase;
   logic        in_access;
   logic        stable;
   logic        access_ok;
   logic        access_viol;
   logic        ready;
   logic [5:0]  idx;
   logic        err;
   logic        commit;
   logic [31:0] rd_val;

   assign setup_phase  = psel_i & ~penable_i;
   assign access_phase = psel_i & penable_i;
   assign in_access    = (state == S_ACCESS);
   // The requester must keep address, direction and data steady for the whole access.
   assign stable       = (paddr_i == paddr_q) && (pwrite_i == pwrite_q) && (pwdata_i == pwdata_q);
   assign access_ok    = in_access & access_phase & stable;
   assign access_viol  = in_access & ~(access_phase & stable);
   assign ready        = access_ok & (wait_cnt == 4'd0);

   // Decode runs on the latched setup values. It does not use the live bus.
   assign idx    = paddr_q[7:2];
   assign err    = (paddr_q[31:8] != BASE_ADDR[31:8])
                 | ({1'b0, idx} >= NUM_REGS_W)
                 | (pwrite_q & (idx == 6'd0));
   assign commit = ready & pwrite_q & ~err;

   // Read mux: index 0 returns the ID word. Out-of-window indices return zero.
   always_comb begin
      // NOTE: default first so every path assigns rd_val and no latch is inferred.
      rd_val = '0;
      if (idx == 6'd0) rd_val = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (idx == 6'(i)) rd_val = regs[i];
      end
   end

   assign pready_o    = ready;
   assign pslverr_o   = ready & err;
   assign prdata_o    = (ready & ~pwrite_q & ~err) ? rd_val : 32'h0;
   assign proto_err_o = proto_err_q;

   // Transfer FSM. It also latches setup values, counts wait states and tracks the sticky violation flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         wait_cnt    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every branch below sees the pre-edge values.
         if (setup_phase) begin
            paddr_q  <= paddr_i;
            pwrite_q <= pwrite_i;
            pwdata_q <= pwdata_i;
            wait_cnt <= WAIT_LOAD;
         end else if (access_ok && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         case (state)
            S_IDLE: begin
               if (penable_i) begin
                  proto_err_q <= 1'b1;             // access phase with no setup phase
               end else if (setup_phase) begin
                  state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (setup_phase) begin
                  proto_err_q <= 1'b1;             // setup phase held longer than one cycle
                  state       <= S_IDLE;
               end else begin
                  state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (access_viol) begin
                  proto_err_q <= 1'b1;             // psel dropped, or the bus changed mid-access
                  state       <= S_IDLE;
               end else if (ready) begin
                  state <= S_IDLE;                 // a back-to-back setup is taken up from IDLE
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Register bank. A write lands only on the completing edge of an error-free write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the register bank is reset on purpose so software always reads zeros after reset.
         for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (commit && idx == 6'(i)) regs[i] <= pwdata_q;
         end
      end
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed bench for apb_reg_slave.
// The main instance uses the default parameters. A second instance with NUM_REGS=16 shares
// the same bus and is used to exercise the top of a smaller register window.
module tb_apb_reg_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata, prdata16;
   logic        pready, pready16, pslverr, pslverr16, proto_err, proto_err16;

   int checks = 0;
   int errors = 0;

   // Penable cycles up to completion: one cycle while the FSM is in SETUP, then the ACCESS cycles.
`ifdef APB_SLV_WAIT_EN
   localparam int EXP_N = 4;
`else
   localparam int EXP_N = 2;
`endif

   // Results of the most recent transfer.
   logic [31:0] r_data, r16_data;
   logic        r_err, r16_err;
   int          r_n;

   always #5 clk = ~clk;

   apb_reg_slave #(.NUM_REGS(64), .BASE_ADDR(32'hDEAD_CA00), .ID_VALUE(32'hA9B0_0016), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset), .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
      .pslverr_o(pslverr), .proto_err_o(proto_err)
   );

   apb_reg_slave #(.NUM_REGS(16), .BASE_ADDR(32'hDEAD_CA00), .ID_VALUE(32'hA9B0_0016), .WAIT_CYCLES(2)) u_dut16 (
      .clk(clk), .reset(reset), .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata16), .pready_o(pready16),
      .pslverr_o(pslverr16), .proto_err_o(proto_err16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Hold the given bus values for one clock. Returns just after the rising edge.
   task automatic drive(input logic s, input logic e, input logic [31:0] a, input logic w, input logic [31:0] d);
      psel = s; penable = e; paddr = a; pwrite = w; pwdata = d;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; psel = 1'b0; penable = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // One legal transfer, started just after a rising edge. It ends with the bus idle.
   // A following call therefore runs back-to-back.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
      bit done = 0;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      r_n = 0; r_data = '0; r_err = 1'b0; r16_data = '0; r16_err = 1'b0;
      while (!done && r_n < 20) begin
         @(negedge clk);
         r_n++;
         if (pready) begin
            r_data = prdata; r_err = pslverr; r16_data = prdata16; r16_err = pslverr16;
            done = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!done) check("xfer_timeout", 32'(r_n), 32'(EXP_N));
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_data, input logic exp_err);
      xfer(a, 1'b0, 32'h0);
      check({tag, "_prdata"}, r_data, exp_data);
      check({tag, "_pslverr"}, 32'(r_err), 32'(exp_err));
      check({tag, "_cycles"}, 32'(r_n), 32'(EXP_N));
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic exp_err);
      xfer(a, 1'b1, d);
      check({tag, "_prdata"}, r_data, 32'h0);
      check({tag, "_pslverr"}, 32'(r_err), 32'(exp_err));
      check({tag, "_cycles"}, 32'(r_n), 32'(EXP_N));
   endtask

   initial begin
      reset = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
      #3;
      check("rst_pready", 32'(pready), 32'h0);
      check("rst_pslverr", 32'(pslverr), 32'h0);
      check("rst_prdata", prdata, 32'h0);
      check("rst_proto_err", 32'(proto_err), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: write, then read back-to-back from the same index
      wr("t1_wr", 32'hDEAD_CA08, 32'h1234_5678, 1'b0);
      rd("t1_rd", 32'hDEAD_CA08, 32'h1234_5678, 1'b0);

      // 2: ID register reads, and a write to it is rejected
      rd("t2_id", 32'hDEAD_CA00, 32'hA9B0_0016, 1'b0);
      wr("t2_id_wr", 32'hDEAD_CA00, 32'hFFFF_FFFF, 1'b1);
      rd("t2_id_again", 32'hDEAD_CA00, 32'hA9B0_0016, 1'b0);

      // 3: top of the 64-register window; the same address is out of range for 16 registers
      rd("t3_idx63_rst", 32'hDEAD_CAFE, 32'h0, 1'b0);
      check("t3_n16_rd_pslverr", 32'(r16_err), 32'h1);
      wr("t3_idx63_wr", 32'hDEAD_CAFE, 32'hCAFE_F00D, 1'b0);
      check("t3_n16_wr_pslverr", 32'(r16_err), 32'h1);
      rd("t3_idx63_rd", 32'hDEAD_CAFE, 32'hCAFE_F00D, 1'b0);
      check("t3_n16_pslverr", 32'(r16_err), 32'h1);
      check("t3_n16_prdata", r16_data, 32'h0);
      wr("t3_idx15_wr", 32'hDEAD_CA3C, 32'h0F0F_0F0F, 1'b0);
      check("t3_n16_idx15_wr_pslverr", 32'(r16_err), 32'h0);
      rd("t3_idx15_rd", 32'hDEAD_CA3C, 32'h0F0F_0F0F, 1'b0);
      check("t3_n16_idx15_pslverr", 32'(r16_err), 32'h0);
      check("t3_n16_idx15_prdata", r16_data, 32'h0F0F_0F0F);

      // 4: addresses outside the window error out and change nothing
      rd("t4_beef_rd", 32'hBEEF_0004, 32'h0, 1'b1);
      wr("t4_beef_wr", 32'hBEEF_0008, 32'hDEAD_BEEF, 1'b1);
      rd("t4_cb08_rd", 32'hDEAD_CB08, 32'h0, 1'b1);
      rd("t4_keep", 32'hDEAD_CA08, 32'h1234_5678, 1'b0);

      // 5: reset in the middle of a write aborts it
      drive(1'b1, 1'b0, 32'hDEAD_CA10, 1'b1, 32'h5);
      penable = 1'b1;
`ifdef APB_SLV_WAIT_EN
      @(posedge clk); #1;
`endif
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t5_rst_pready", 32'(pready), 32'h0);
      check("t5_rst_pslverr", 32'(pslverr), 32'h0);
      check("t5_rst_prdata", prdata, 32'h0);
      check("t5_rst_proto_err", 32'(proto_err), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; psel = 1'b0; penable = 1'b0;
      rd("t5_reg10", 32'hDEAD_CA10, 32'h0, 1'b0);
      rd("t5_reg08", 32'hDEAD_CA08, 32'h0, 1'b0);

      // 6: requester protocol violations, each started from a fresh reset
      for (int c = 0; c < 4; c++) begin
         do_reset();
         check("t6_clear", 32'(proto_err), 32'h0);
         case (c)
            0: begin   // penable with no setup phase
               drive(1'b1, 1'b1, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
            end
            1: begin   // setup phase lasting two cycles
               drive(1'b1, 1'b0, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
               drive(1'b1, 1'b0, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
               drive(1'b1, 1'b1, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
               drive(1'b1, 1'b1, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
            end
            2: begin   // address changes while the FSM is in ACCESS
               drive(1'b1, 1'b0, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
               drive(1'b1, 1'b1, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
               drive(1'b1, 1'b1, 32'hDEAD_CA14, 1'b1, 32'hAAAA_5555);
               drive(1'b1, 1'b1, 32'hDEAD_CA14, 1'b1, 32'hAAAA_5555);
            end
            default: begin   // psel dropped before completion
               drive(1'b1, 1'b0, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
               drive(1'b1, 1'b1, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
               drive(1'b0, 1'b0, 32'hDEAD_CA08, 1'b1, 32'hAAAA_5555);
            end
         endcase
         drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         check($sformatf("t6_case%0d_flag", c), 32'(proto_err), 32'h1);
         rd($sformatf("t6_case%0d_rd08", c), 32'hDEAD_CA08, 32'h0, 1'b0);
         if (c == 2) rd("t6_case2_rd14", 32'hDEAD_CA14, 32'h0, 1'b0);
         check($sformatf("t6_case%0d_sticky", c), 32'(proto_err), 32'h1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
